// File: rtl/delay_measure_ctrl.sv
// Delay-line measurement sequencer: settle chain input low, launch an edge, count cycles until it returns.
// Latency: launch rises SETTLE+1 cycles after start is sampled; result = chain delay + 2 (synchronizer).
// No backpressure: start is sampled only in IDLE, requests while busy are dropped. Option: DELAY_MINMAX_EN.
module delay_measure_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024,
    parameter int SETTLE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             path_in,
`ifdef DELAY_MINMAX_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] min_cycles,
    output logic [CNT_W-1:0] max_cycles,
`endif
    output logic             launch,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] meas_cycles
);

    localparam int STL_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [STL_W-1:0] STL_MAX = STL_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [STL_W-1:0] stl, stl_nxt;
    logic             launch_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             timeout_nxt;
    logic [CNT_W-1:0] meas_nxt;
    logic             sync1;
    logic             sync_q;

    // Two-flop synchronizer: path_in is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync1  <= path_in;
            sync_q <= sync1;
        end
    end

    // State, counters and all outputs are registered from the next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            stl         <= '0;
            launch      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            meas_cycles <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            stl         <= stl_nxt;
            launch      <= launch_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            meas_cycles <= meas_nxt;
        end
    end

    // Next-state and output decode; cnt only increments below TMO so it saturates there.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        stl_nxt     = stl;
        launch_nxt  = launch;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        timeout_nxt = timeout;
        meas_nxt    = meas_cycles;
        case (state)
            S_IDLE: begin
                launch_nxt = 1'b0;
                busy_nxt   = 1'b0;
                if (start) begin
                    state_nxt = S_PREP;
                    cnt_nxt   = '0;
                    stl_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            S_PREP: begin
                launch_nxt = 1'b0;
                if (stl == STL_MAX) begin
                    // Chain output has been low long enough: launch and restart the count.
                    state_nxt  = S_WAIT;
                    launch_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else if (cnt == TMO) begin
                    // Chain output never went quiet; abort without launching.
                    state_nxt   = S_DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    meas_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    stl_nxt = sync_q ? '0 : stl + STL_W'(1);
                end
            end
            S_WAIT: begin
                if (sync_q) begin
                    state_nxt   = S_DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b0;
                    meas_nxt    = cnt;
                    launch_nxt  = 1'b0;
                end else if (cnt == TMO) begin
                    state_nxt   = S_DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    meas_nxt    = TMO;
                    launch_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt  = S_IDLE;
                launch_nxt = 1'b0;
                busy_nxt   = 1'b0;
            end
            default: begin
                state_nxt  = S_IDLE;
                launch_nxt = 1'b0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

`ifdef DELAY_MINMAX_EN
    logic stats_upd;
    assign stats_upd = (state == S_WAIT) && sync_q;

    // Running min/max of successful results; clear takes priority over a same-cycle update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_cycles <= '1;
            max_cycles <= '0;
        end else if (stats_clr) begin
            min_cycles <= '1;
            max_cycles <= '0;
        end else if (stats_upd) begin
            if (cnt < min_cycles) min_cycles <= cnt;
            if (cnt > max_cycles) max_cycles <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_delay_measure_ctrl.sv
// Directed bench for delay_measure_ctrl: two instances (long and short timeout) driven by a
// delay-chain model that echoes launch after D whole cycles, or ties path_in low/high.
module tb_delay_measure_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        go    = 1'b0;
    int          sel   = 0;
    int          chain_d = 0;
    int          mode  = 0;   // 0 chain model, 1 tied low, 2 tied high
    int          checks = 0;
    int          errors = 0;

    logic        start1, start2, path1, path2;
    logic        launch1, busy1, done1, to1;
    logic        launch2, busy2, done2, to2;
    logic [31:0] meas1, meas2;
    logic [127:0] h1 = '0;
    logic [127:0] h2 = '0;

    logic        c_launch, c_busy, c_done, c_to;
    logic [31:0] c_meas;

`ifdef DELAY_MINMAX_EN
    logic        clr1 = 1'b0;
    logic        clr2 = 1'b0;
    logic [31:0] min1, max1, min2, max2;
`endif

    assign start1   = go && (sel == 0);
    assign start2   = go && (sel == 1);
    assign c_launch = (sel == 1) ? launch2 : launch1;
    assign c_busy   = (sel == 1) ? busy2   : busy1;
    assign c_done   = (sel == 1) ? done2   : done1;
    assign c_to     = (sel == 1) ? to2     : to1;
    assign c_meas   = (sel == 1) ? meas2   : meas1;

    function automatic logic chain_out(input int m, input int d, input logic l, input logic [127:0] h);
        if (m == 1) return 1'b0;
        if (m == 2) return 1'b1;
        if (d == 0) return l;
        return h[d-1];
    endfunction

    always @(posedge clk) begin
        h1 <= {h1[126:0], launch1};
        h2 <= {h2[126:0], launch2};
    end

    always_comb path1 = chain_out(mode, chain_d, launch1, h1);
    always_comb path2 = chain_out(mode, chain_d, launch2, h2);

    delay_measure_ctrl #(.CNT_W(32), .TIMEOUT(1024), .SETTLE(4)) dut (
        .clk(clk), .rst(rst), .start(start1), .path_in(path1),
`ifdef DELAY_MINMAX_EN
        .stats_clr(clr1), .min_cycles(min1), .max_cycles(max1),
`endif
        .launch(launch1), .busy(busy1), .done(done1), .timeout(to1), .meas_cycles(meas1)
    );

    delay_measure_ctrl #(.CNT_W(32), .TIMEOUT(16), .SETTLE(4)) dut_to (
        .clk(clk), .rst(rst), .start(start2), .path_in(path2),
`ifdef DELAY_MINMAX_EN
        .stats_clr(clr2), .min_cycles(min2), .max_cycles(max2),
`endif
        .launch(launch2), .busy(busy2), .done(done2), .timeout(to2), .meas_cycles(meas2)
    );

    // Let the chain model drain and both instances go idle before a new run.
    task automatic wait_quiet();
        bit q = 0;
        for (int k = 0; k < 300 && !q; k++) begin
            @(negedge clk);
            q = (h1 == '0) && (h2 == '0) && !busy1 && !busy2;
        end
        checks++;
        if (!q) begin
            errors++;
            $display("FAIL quiet: chain/instances still active after 300 cycles (busy1=%0b busy2=%0b)", busy1, busy2);
        end
    endtask

    // One start pulse; reports cycles (negedges after start) to launch rise and to done.
    task automatic do_run(input int s, input int d, input int m,
                          output logic [31:0] meas, output logic tmo,
                          output int lat, output int dur, output bit seen);
        sel = s; chain_d = d; mode = m;
        wait_quiet();
        meas = '0; tmo = 1'b0; lat = -1; dur = -1; seen = 0;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        for (int k = 1; k <= 400 && !seen; k++) begin
            @(negedge clk);
            if (c_launch && lat < 0) lat = k;
            if (c_done) begin
                seen = 1; dur = k; meas = c_meas; tmo = c_to;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (launch1 !== 1'b0) begin errors++; $display("FAIL reset_launch: got %b want 0", launch1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done1); end
        checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", to1); end
        checks++; if (meas1 !== 32'd0) begin errors++; $display("FAIL reset_meas: got %0d want 0", meas1); end
        checks++; if (meas2 !== 32'd0) begin errors++; $display("FAIL reset_meas2: got %0d want 0", meas2); end
`ifdef DELAY_MINMAX_EN
        checks++; if (min1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_min: got %h want ffffffff", min1); end
        checks++; if (max1 !== 32'd0) begin errors++; $display("FAIL reset_max: got %0d want 0", max1); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] m; logic t; int lat, dur; bit seen;
        do_run(0, 5, 0, m, t, lat, dur, seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_done: got no done want done"); end
        checks++; if (lat != 5) begin errors++; $display("FAIL basic_launch_lat: got %0d want 5", lat); end
        checks++; if (dur != 13) begin errors++; $display("FAIL basic_done_lat: got %0d want 13", dur); end
        checks++; if (m !== 32'd7) begin errors++; $display("FAIL basic_meas: got %0d want 7", m); end
        checks++; if (t !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", t); end
        @(negedge clk);
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy1); end
        checks++; if (meas1 !== 32'd7) begin errors++; $display("FAIL basic_meas_hold: got %0d want 7", meas1); end
    endtask

    task automatic test_chain();
        logic [31:0] m; logic t; int lat, dur; bit seen;
        do_run(0, 0, 0, m, t, lat, dur, seen);
        checks++; if (!seen || m !== 32'd2) begin errors++; $display("FAIL chain_d0: got %0d want 2 (seen=%0d)", m, seen); end
        checks++; if (dur != 8) begin errors++; $display("FAIL chain_d0_lat: got %0d want 8", dur); end
        do_run(0, 100, 0, m, t, lat, dur, seen);
        checks++; if (!seen || m !== 32'd102) begin errors++; $display("FAIL chain_d100: got %0d want 102 (seen=%0d)", m, seen); end
        checks++; if (t !== 1'b0) begin errors++; $display("FAIL chain_d100_timeout: got %b want 0", t); end
    endtask

    task automatic test_timeout();
        logic [31:0] m; logic t; int lat, dur; bit seen;
        do_run(1, 0, 1, m, t, lat, dur, seen);
        checks++; if (!seen || m !== 32'd16) begin errors++; $display("FAIL wait_timeout_meas: got %0d want 16 (seen=%0d)", m, seen); end
        checks++; if (t !== 1'b1) begin errors++; $display("FAIL wait_timeout_flag: got %b want 1", t); end
        checks++; if (dur != 22) begin errors++; $display("FAIL wait_timeout_lat: got %0d want 22", dur); end
        repeat (3) @(negedge clk);
        checks++; if (meas2 !== 32'd16 || to2 !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %0d/%b want 16/1", meas2, to2); end
        do_run(1, 0, 2, m, t, lat, dur, seen);
        checks++; if (!seen || m !== 32'd0) begin errors++; $display("FAIL prep_timeout_meas: got %0d want 0 (seen=%0d)", m, seen); end
        checks++; if (t !== 1'b1) begin errors++; $display("FAIL prep_timeout_flag: got %b want 1", t); end
        checks++; if (lat != -1) begin errors++; $display("FAIL prep_timeout_launch: launch rose at %0d want never", lat); end
        checks++; if (dur != 17) begin errors++; $display("FAIL prep_timeout_lat: got %0d want 17", dur); end
        mode = 0;
    endtask

    task automatic test_mid_reset();
        bit up = 0;
        bit pulsed = 0;
        sel = 0; chain_d = 100; mode = 0;
        wait_quiet();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        for (int k = 0; k < 20 && !up; k++) begin
            @(negedge clk);
            up = launch1;
        end
        checks++; if (!up) begin errors++; $display("FAIL midrst_launch_rise: got 0 want 1"); end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (launch1 !== 1'b0) begin errors++; $display("FAIL midrst_launch: got %b want 0", launch1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy1); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (done1) pulsed = 1;
        end
        checks++; if (pulsed) begin errors++; $display("FAIL midrst_done: got pulse want none"); end
        checks++; if (meas1 !== 32'd0) begin errors++; $display("FAIL midrst_meas: got %0d want 0", meas1); end
    endtask

    task automatic test_back_to_back();
        int   dt[3];
        logic [31:0] dm[3];
        logic dtm[3];
        int   n = 0;
        int   rises = 0;
        logic prev = 1'b0;
        sel = 0; chain_d = 3; mode = 0;
        wait_quiet();
        @(negedge clk); go = 1'b1;
        for (int k = 1; k <= 100 && n < 3; k++) begin
            @(negedge clk);
            if (launch1 && !prev) rises++;
            prev = launch1;
            if (done1) begin
                dt[n] = k; dm[n] = meas1; dtm[n] = to1; n++;
            end
        end
        go = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d runs want 3", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (dm[i] !== 32'd5 || dtm[i] !== 1'b0) begin
                errors++; $display("FAIL b2b_meas%0d: got %0d/%b want 5/0", i, dm[i], dtm[i]);
            end
        end
        if (n == 3) begin
            checks++; if (dt[1] - dt[0] != 16) begin errors++; $display("FAIL b2b_gap1: got %0d want 16", dt[1] - dt[0]); end
            checks++; if (dt[2] - dt[1] != 16) begin errors++; $display("FAIL b2b_gap2: got %0d want 16", dt[2] - dt[1]); end
        end
        checks++; if (rises != 3) begin errors++; $display("FAIL b2b_launches: got %0d want 3", rises); end
    endtask

`ifdef DELAY_MINMAX_EN
    task automatic test_stats();
        logic [31:0] m; logic t; int lat, dur; bit seen;
        @(negedge clk); clr1 = 1'b1; clr2 = 1'b1;
        @(negedge clk); clr1 = 1'b0; clr2 = 1'b0;
        do_run(0, 3, 0, m, t, lat, dur, seen);
        do_run(0, 9, 0, m, t, lat, dur, seen);
        do_run(0, 6, 0, m, t, lat, dur, seen);
        checks++; if (m !== 32'd8) begin errors++; $display("FAIL stats_last_meas: got %0d want 8", m); end
        checks++; if (min1 !== 32'd5) begin errors++; $display("FAIL stats_min: got %0d want 5", min1); end
        checks++; if (max1 !== 32'd11) begin errors++; $display("FAIL stats_max: got %0d want 11", max1); end
        @(negedge clk); clr1 = 1'b1;
        @(negedge clk); clr1 = 1'b0;
        checks++; if (min1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_clr_min: got %h want ffffffff", min1); end
        checks++; if (max1 !== 32'd0) begin errors++; $display("FAIL stats_clr_max: got %0d want 0", max1); end
        do_run(1, 3, 0, m, t, lat, dur, seen);
        checks++; if (min2 !== 32'd5 || max2 !== 32'd5) begin errors++; $display("FAIL stats_one: got %0d/%0d want 5/5", min2, max2); end
        do_run(1, 0, 1, m, t, lat, dur, seen);
        checks++; if (t !== 1'b1) begin errors++; $display("FAIL stats_tmo_flag: got %b want 1", t); end
        checks++; if (min2 !== 32'd5 || max2 !== 32'd5) begin errors++; $display("FAIL stats_tmo_keep: got %0d/%0d want 5/5", min2, max2); end
        mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
`ifdef DELAY_MINMAX_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
